// File: rtl/counter_sequence_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequence_checker_if
// Description : Observed-counter and status bundle for the sequence checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_sequence_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) ();
  logic                 mon_enable;
  logic                 mon_clear;
  logic [WIDTH-1:0]     counter_in;
  logic                 err_clear;
  logic                 locked;
  logic                 error;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] error_count;
  logic [WIDTH-1:0]     first_exp;
  logic [WIDTH-1:0]     first_got;

  modport master (
    output mon_enable, mon_clear, counter_in, err_clear,
    input  locked, error, err_pulse, error_count, first_exp, first_got
  );

  modport slave (
    input  mon_enable, mon_clear, counter_in, err_clear,
    output locked, error, err_pulse, error_count, first_exp, first_got
  );
endinterface
`default_nettype wire

// File: rtl/counter_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequence_checker
// Description : Predicts an enable-gated up counter and flags deviations.
//               Optional macro CHECKER_HALT_ON_ERR_EN freezes on first error.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequence_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int SYNC_LEN  = 2
) (
  input  wire                          clk,
  input  wire                          reset,
  counter_sequence_checker_if.slave    bus
);

  localparam logic [1:0] UNSYNC  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;
`ifdef CHECKER_HALT_ON_ERR_EN
  localparam logic [1:0] HALTED  = 2'd3;
`endif

  localparam logic [3:0]           C_SYNC_LEN = 4'(SYNC_LEN);
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_en_q;
  logic                 r_clr_q;
  logic [3:0]           r_match_cnt;
  logic                 r_error;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_error_count;
  logic [WIDTH-1:0]     r_first_exp;
  logic [WIDTH-1:0]     r_first_got;

  logic [WIDTH-1:0]     w_exp;
  logic                 w_match;
  logic [3:0]           w_match_nxt;
  logic                 w_trk_mismatch;
  logic                 w_clr_allowed;

  // Clear outranks enable, mirroring the counter's own priority.
  assign w_exp          = r_clr_q ? '0 : (r_en_q ? r_prev + WIDTH'(1) : r_prev);
  assign w_match        = (bus.counter_in == w_exp);
  assign w_match_nxt    = r_match_cnt + 4'd1;
  assign w_trk_mismatch = (r_state == TRACK) && !w_match;

`ifdef CHECKER_HALT_ON_ERR_EN
  assign w_clr_allowed  = (r_state != HALTED);
`else
  assign w_clr_allowed  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= UNSYNC;
      r_prev        <= '0;
      r_en_q        <= 1'b0;
      r_clr_q       <= 1'b0;
      r_match_cnt   <= '0;
      r_error       <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_error_count <= '0;
      r_first_exp   <= '0;
      r_first_got   <= '0;
    end else begin
      // Always re-seed from the observation so one glitch costs one error.
      r_prev      <= bus.counter_in;
      r_en_q      <= bus.mon_enable;
      r_clr_q     <= bus.mon_clear;
      r_err_pulse <= 1'b0;

      case (r_state)
        UNSYNC: begin
          r_match_cnt <= '0;
          r_state     <= ACQUIRE;
        end
        ACQUIRE: begin
          if (w_match) begin
            r_match_cnt <= w_match_nxt;
            if (w_match_nxt == C_SYNC_LEN) begin
              r_state <= TRACK;
            end
          end else begin
            r_match_cnt <= '0;
          end
        end
        TRACK: begin
`ifdef CHECKER_HALT_ON_ERR_EN
          if (!w_match) begin
            r_state <= HALTED;
          end
`endif
        end
`ifdef CHECKER_HALT_ON_ERR_EN
        HALTED: begin
          r_state <= HALTED;
        end
`endif
        default: r_state <= UNSYNC;
      endcase

      // A mismatch in the same cycle as err_clear restarts the record.
      if (w_trk_mismatch) begin
        r_err_pulse <= 1'b1;
        r_error     <= 1'b1;
        if (bus.err_clear) begin
          r_error_count <= C_ERR_ONE;
        end else if (r_error_count != C_ERR_MAX) begin
          r_error_count <= r_error_count + C_ERR_ONE;
        end
        if (!r_error || bus.err_clear) begin
          r_first_exp <= w_exp;
          r_first_got <= bus.counter_in;
        end
      end else if (bus.err_clear && w_clr_allowed) begin
        r_error       <= 1'b0;
        r_error_count <= '0;
      end
    end
  end

  assign bus.locked      = (r_state == TRACK);
  assign bus.error       = r_error;
  assign bus.err_pulse   = r_err_pulse;
  assign bus.error_count = r_error_count;
  assign bus.first_exp   = r_first_exp;
  assign bus.first_got   = r_first_got;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequence_checker
// Description : Directed self-checking bench for counter_sequence_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequence_checker;

  localparam int WIDTH     = 4;
  localparam int ERR_CNT_W = 2;
  localparam int SYNC_LEN  = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  counter_sequence_checker_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  counter_sequence_checker #(
    .WIDTH    (WIDTH),
    .ERR_CNT_W(ERR_CNT_W),
    .SYNC_LEN (SYNC_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one sample, then observe just after the capturing edge.
  task automatic step(input logic clr, input logic en, input logic [WIDTH-1:0] cnt,
                      input logic eclr);
    bus.mon_clear  = clr;
    bus.mon_enable = en;
    bus.counter_in = cnt;
    bus.err_clear  = eclr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic lk, input logic er,
                              input logic pu, input logic [ERR_CNT_W-1:0] cnt);
    check({tag, ".locked"},    32'(bus.locked),      32'(lk));
    check({tag, ".error"},     32'(bus.error),       32'(er));
    check({tag, ".err_pulse"}, 32'(bus.err_pulse),   32'(pu));
    check({tag, ".count"},     32'(bus.error_count), 32'(cnt));
  endtask

  task automatic check_first(input string tag, input logic [WIDTH-1:0] e,
                             input logic [WIDTH-1:0] g);
    check({tag, ".first_exp"}, 32'(bus.first_exp), 32'(e));
    check({tag, ".first_got"}, 32'(bus.first_got), 32'(g));
  endtask

  task automatic acquire();
    step(1'b1, 1'b0, 4'd5, 1'b0);
    check("acq_seed.locked", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    check("acq_1.locked", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    check_status("acq_lock", 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset          = 1'b0;
    bus.mon_clear  = 1'b0;
    bus.mon_enable = 1'b0;
    bus.counter_in = '0;
    bus.err_clear  = 1'b0;

    step(1'b0, 1'b1, 4'd3, 1'b1);
    step(1'b1, 1'b1, 4'd7, 1'b0);
    check_status("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    check_first("reset", 4'd0, 4'd0);
    reset = 1'b1;

    acquire();

`ifdef CHECKER_HALT_ON_ERR_EN
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 1'b1, 4'd9, 1'b0);
    check_status("halt_err1", 1'b0, 1'b1, 1'b1, 2'd1);
    check_first("halt_err1", 4'd4, 4'd9);
    step(1'b0, 1'b1, 4'd12, 1'b0);
    check_status("halt_err2", 1'b0, 1'b1, 1'b0, 2'd1);
    check_first("halt_err2", 4'd4, 4'd9);
    step(1'b0, 1'b1, 4'd13, 1'b1);
    check_status("halt_eclr", 1'b0, 1'b1, 1'b0, 2'd1);
    reset = 1'b0;
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check_status("halt_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    acquire();
`else
    for (int v = 2; v <= 11; v++) step(1'b0, 1'b1, 4'(v), 1'b0);
    check_status("count11", 1'b1, 1'b0, 1'b0, 2'd0);

    // 12..15 then wrap to 0..5
    for (int v = 12; v <= 21; v++) step(1'b0, 1'b1, 4'(v % 16), 1'b0);
    check_status("wrap", 1'b1, 1'b0, 1'b0, 2'd0);

    step(1'b0, 1'b1, 4'd7, 1'b0);
    check_status("glitch", 1'b1, 1'b1, 1'b1, 2'd1);
    check_first("glitch", 4'd6, 4'd7);
    step(1'b0, 1'b1, 4'd8, 1'b0);
    check_status("after_glitch", 1'b1, 1'b1, 1'b0, 2'd1);

    step(1'b0, 1'b0, 4'd9, 1'b0);
    check("hold_ok.count", 32'(bus.error_count), 32'd1);
    step(1'b0, 1'b0, 4'd10, 1'b0);
    check_status("hold_e2", 1'b1, 1'b1, 1'b1, 2'd2);
    step(1'b0, 1'b0, 4'd11, 1'b0);
    check("hold_e3.count", 32'(bus.error_count), 32'd3);
    step(1'b0, 1'b0, 4'd12, 1'b0);
    check("hold_sat.count", 32'(bus.error_count), 32'd3);
    check_first("hold_sat", 4'd6, 4'd7);

    step(1'b0, 1'b0, 4'd12, 1'b1);
    check_status("eclr", 1'b1, 1'b0, 1'b0, 2'd0);
    check_first("eclr", 4'd6, 4'd7);
    step(1'b0, 1'b0, 4'd13, 1'b1);
    check_status("eclr_coinc", 1'b1, 1'b1, 1'b1, 2'd1);
    check_first("eclr_coinc", 4'd12, 4'd13);

    step(1'b1, 1'b0, 4'd13, 1'b1);
    check_status("pre_clr", 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 4'd9, 1'b0);
    check_status("clr_miss", 1'b1, 1'b1, 1'b1, 2'd1);
    check_first("clr_miss", 4'd0, 4'd9);

    reset = 1'b0;
    step(1'b0, 1'b1, 4'd3, 1'b0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    check_first("mid_rst", 4'd0, 4'd0);
    reset = 1'b1;
    step(1'b0, 1'b1, 4'd4, 1'b0);
    check("relock_seed.locked", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    check("relock_1.locked", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b1, 4'd6, 1'b0);
    check_status("relock", 1'b1, 1'b0, 1'b0, 2'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
